// File: rtl/nx_msg_encoder.sv
// ---------------------------------------------------------------------------
// nx_msg_encoder
//
// Packs a mesh request into a single outbound message word, picks the output
// direction (row first, then column) relative to this node's own position,
// and buffers {message, direction} in a 2-entry register FIFO so that the
// request side never sees a combinational path from the outbound ready.
// Requests addressed to this node itself are accepted and dropped.
//
// Ports
//   clk_i          : clock, all state on the rising edge
//   rst_i          : asynchronous active-high reset
//   node_row_i     : this encoder's mesh row
//   node_col_i     : this encoder's mesh column
//   req_row_i      : target row
//   req_col_i      : target column
//   req_cmd_i      : command (0 LOAD_INSTR, 1 MAP_IO, 2 SIG_STATE, 3 CONTROL)
//   req_bcast_i    : broadcast flag
//   req_payload_i  : command payload, passed through unmodified
//   req_valid_i    : request valid
//   req_ready_o    : request ready (FIFO not full)
//   msg_data_o     : encoded message at the FIFO head
//   msg_dir_o      : direction of the head message (0 N, 1 E, 2 S, 3 W)
//   msg_valid_o    : outbound valid (FIFO not empty)
//   msg_ready_i    : outbound ready
//   sent_count_o   : saturating count of emitted messages
//   drop_count_o   : saturating count of self-addressed drops
//   idle_o         : FIFO empty and no request pending
// ---------------------------------------------------------------------------
module nx_msg_encoder #(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 2
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0]                               node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]                               node_col_i,
  input  logic [ADDR_ROW_WIDTH-1:0]                               req_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]                               req_col_i,
  input  logic [COMMAND_WIDTH-1:0]                                req_cmd_i,
  input  logic                                                    req_bcast_i,
  input  logic [STREAM_WIDTH-ADDR_ROW_WIDTH-ADDR_COL_WIDTH-COMMAND_WIDTH-2:0] req_payload_i,
  input  logic                                                    req_valid_i,
  output logic                                                    req_ready_o,
  output logic [STREAM_WIDTH-1:0]                                 msg_data_o,
  output logic [1:0]                                              msg_dir_o,
  output logic                                                    msg_valid_o,
  input  logic                                                    msg_ready_i,
  output logic [15:0]                                             sent_count_o,
  output logic [15:0]                                             drop_count_o,
  output logic                                                    idle_o
);

  localparam int PAYLOAD_WIDTH =
    STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH - 1;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    DIR_NORTH = 2'd0,
    DIR_EAST  = 2'd1,
    DIR_SOUTH = 2'd2,
    DIR_WEST  = 2'd3
  } dir_e;

  // FIFO storage and bookkeeping
  logic [STREAM_WIDTH-1:0] data_q [2];
  logic [1:0]              dir_q  [2];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              count_q;

  logic [15:0]             sent_cnt_q;
  logic [15:0]             drop_cnt_q;

  // Request decode
  logic [STREAM_WIDTH-1:0]  enc_data;
  logic [PAYLOAD_WIDTH-1:0] payload;
  dir_e                     enc_dir;
  logic                     self_addr;
  logic                     full;
  logic                     empty;
  logic                     accept;
  logic                     push;
  logic                     pop;

  assign payload  = req_payload_i;
  assign enc_data = {req_row_i, req_col_i, req_cmd_i, req_bcast_i, payload};

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never opens the door for a request while full.
  assign req_ready_o = !full;
  assign msg_valid_o = !empty;

  assign self_addr = (req_row_i == node_row_i) && (req_col_i == node_col_i);
  assign accept    = req_valid_i && req_ready_o;
  assign push      = accept && !self_addr;
  assign pop       = msg_valid_o && msg_ready_i;

  // Route row first, then column. A self-addressed request falls through to
  // the default, but it is never stored so the value does not matter.
  always_comb begin
    enc_dir = DIR_NORTH;
    if (req_row_i > node_row_i) begin
      enc_dir = DIR_SOUTH;
    end else if (req_row_i < node_row_i) begin
      enc_dir = DIR_NORTH;
    end else if (req_col_i > node_col_i) begin
      enc_dir = DIR_EAST;
    end else if (req_col_i < node_col_i) begin
      enc_dir = DIR_WEST;
    end
  end

  // Entry storage. The direction is captured at accept time, so later changes
  // to the node position do not affect messages already queued. Entries are
  // cleared on reset so the head reads as zero while reset is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      dir_q[0]  <= '0;
      dir_q[1]  <= '0;
    end else if (push) begin
      data_q[wr_ptr_q] <= enc_data;
      dir_q[wr_ptr_q]  <= enc_dir;
    end
  end

  // Pointers wrap naturally as single bits; occupancy is unchanged when a
  // push and a pop land in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop && (sent_cnt_q != COUNT_MAX)) begin
        sent_cnt_q <= sent_cnt_q + 16'd1;
      end
      if (accept && self_addr && (drop_cnt_q != COUNT_MAX)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign msg_data_o   = data_q[rd_ptr_q];
  assign msg_dir_o    = dir_q[rd_ptr_q];
  assign sent_count_o = sent_cnt_q;
  assign drop_count_o = drop_cnt_q;
  assign idle_o       = empty && !req_valid_i;

endmodule

// File: tb/tb_nx_msg_encoder.sv
// ---------------------------------------------------------------------------
// tb_nx_msg_encoder
//
// Directed bench for nx_msg_encoder. Each cycle the bench model predicts
// ready/valid/idle/counters, compares the FIFO head against a scoreboard of
// expected {data, dir} pushed at accept time, and pops it on handshake.
// ---------------------------------------------------------------------------
module tb_nx_msg_encoder;

  localparam int SW = 32;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int MW = 2;
  localparam int PW = SW - RW - CW - MW - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [RW-1:0] node_row_i;
  logic [CW-1:0] node_col_i;
  logic [RW-1:0] req_row_i;
  logic [CW-1:0] req_col_i;
  logic [MW-1:0] req_cmd_i;
  logic          req_bcast_i;
  logic [PW-1:0] req_payload_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [SW-1:0] msg_data_o;
  logic [1:0]    msg_dir_o;
  logic          msg_valid_o;
  logic          msg_ready_i;
  logic [15:0]   sent_count_o;
  logic [15:0]   drop_count_o;
  logic          idle_o;

  nx_msg_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .node_row_i    (node_row_i),
    .node_col_i    (node_col_i),
    .req_row_i     (req_row_i),
    .req_col_i     (req_col_i),
    .req_cmd_i     (req_cmd_i),
    .req_bcast_i   (req_bcast_i),
    .req_payload_i (req_payload_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .msg_data_o    (msg_data_o),
    .msg_dir_o     (msg_dir_o),
    .msg_valid_o   (msg_valid_o),
    .msg_ready_i   (msg_ready_i),
    .sent_count_o  (sent_count_o),
    .drop_count_o  (drop_count_o),
    .idle_o        (idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dir;
  } exp_t;

  exp_t        exp_q[$];
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          model_cnt = 0;
  logic [15:0] exp_sent  = 16'd0;
  logic [15:0] exp_drop  = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] expData(input int r, input int c, input int cmd,
                                          input int b, input int p);
    return (32'(r) << 28) | (32'(c) << 24) | (32'(cmd) << 22) | (32'(b) << 21) | 32'(p);
  endfunction

  function automatic logic [1:0] expDir(input int r, input int c, input int nr, input int nc);
    if (r != nr) return (r > nr) ? 2'd2 : 2'd0;
    return (c > nc) ? 2'd1 : 2'd3;
  endfunction

  // Drive request side and outbound ready; called just after a falling edge.
  task automatic applyStimulus(input logic v, input int r, input int c, input int cmd,
                               input logic b, input int p, input logic rdy);
    req_valid_i   = v;
    req_row_i     = RW'(r);
    req_col_i     = CW'(c);
    req_cmd_i     = MW'(cmd);
    req_bcast_i   = b;
    req_payload_i = PW'(p);
    msg_ready_i   = rdy;
  endtask

  // Compare against the model ahead of the rising edge, then advance the
  // model and the clock to the next falling edge.
  task automatic checkOutput(input string tag);
    exp_t hd;
    logic pop;
    logic acc;
    #2;
    check({tag, ".req_ready"}, 32'(req_ready_o), 32'(model_cnt != 2));
    check({tag, ".msg_valid"}, 32'(msg_valid_o), 32'(model_cnt != 0));
    check({tag, ".idle"}, 32'(idle_o), 32'((model_cnt == 0) && !req_valid_i));
    check({tag, ".sent"}, 32'(sent_count_o), 32'(exp_sent));
    check({tag, ".drop"}, 32'(drop_count_o), 32'(exp_drop));
    if (model_cnt != 0) begin
      if (exp_q.size() == 0) begin
        check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        hd = exp_q[0];
        check({tag, ".head_data"}, msg_data_o, hd.data);
        check({tag, ".head_dir"}, 32'(msg_dir_o), 32'(hd.dir));
      end
    end
    pop = (model_cnt != 0) && msg_ready_i;
    acc = req_valid_i && (model_cnt != 2);
    if (pop) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_sent != 16'hFFFF) exp_sent++;
    end
    if (acc) begin
      if (req_row_i == node_row_i && req_col_i == node_col_i) begin
        if (exp_drop != 16'hFFFF) exp_drop++;
      end else begin
        hd.data = expData(int'(req_row_i), int'(req_col_i), int'(req_cmd_i),
                          int'(req_bcast_i), int'(req_payload_i));
        hd.dir  = expDir(int'(req_row_i), int'(req_col_i), int'(node_row_i), int'(node_col_i));
        exp_q.push_back(hd);
      end
    end
    model_cnt = model_cnt + ((acc && !(req_row_i == node_row_i && req_col_i == node_col_i)) ? 1 : 0)
                          - (pop ? 1 : 0);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i      = 1'b1;
    node_row_i = 4'd2;
    node_col_i = 4'd2;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);

    // Reset state
    @(negedge clk_i);
    #1;
    check("rst.req_ready", 32'(req_ready_o), 32'd1);
    check("rst.msg_valid", 32'(msg_valid_o), 32'd0);
    check("rst.msg_data", msg_data_o, 32'd0);
    check("rst.msg_dir", 32'(msg_dir_o), 32'd0);
    check("rst.sent", 32'(sent_count_o), 32'd0);
    check("rst.drop", 32'(drop_count_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single message south, known constant encoding
    applyStimulus(1'b1, 3, 2, 1, 1'b0, 'h00ABC, 1'b1);
    checkOutput("single_acc");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    #1;
    check("single.data_const", msg_data_o, 32'h32400ABC);
    check("single.dir_const", 32'(msg_dir_o), 32'd2);
    checkOutput("single_pop");
    check("single.sent_after", 32'(sent_count_o), 32'd1);

    // Back-to-back north, east, west at full throughput
    applyStimulus(1'b1, 1, 2, 0, 1'b0, 'h11111, 1'b1);
    checkOutput("b2b_n");
    applyStimulus(1'b1, 2, 3, 2, 1'b1, 'h02222, 1'b1);
    checkOutput("b2b_e");
    applyStimulus(1'b1, 2, 1, 3, 1'b0, 'h13333, 1'b1);
    checkOutput("b2b_w");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("b2b_drain");
    checkOutput("b2b_idle");

    // Self-addressed request is accepted and dropped
    applyStimulus(1'b1, 2, 2, 1, 1'b0, 'h0BEEF, 1'b1);
    checkOutput("self_acc");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("self_after");

    // Backpressure: three offered, two accepted, third waits for space
    applyStimulus(1'b1, 0, 5, 0, 1'b0, 'h0AAAA, 1'b0);
    checkOutput("bp_a");
    applyStimulus(1'b1, 4, 4, 1, 1'b1, 'h0BBBB, 1'b0);
    checkOutput("bp_b");
    applyStimulus(1'b1, 2, 7, 2, 1'b0, 'h0CCCC, 1'b0);
    checkOutput("bp_c_full");
    checkOutput("bp_hold1");
    checkOutput("bp_hold2");
    msg_ready_i = 1'b1;
    checkOutput("bp_pop_a");
    checkOutput("bp_pop_b_acc_c");
    req_valid_i = 1'b0;
    checkOutput("bp_pop_c");
    checkOutput("bp_idle");

    // Queued direction is fixed at accept, not by later node moves
    applyStimulus(1'b1, 0, 2, 3, 1'b0, 'h1F00F, 1'b0);
    checkOutput("node_acc");
    req_valid_i = 1'b0;
    node_row_i  = 4'd0;
    node_col_i  = 4'd0;
    checkOutput("node_moved");
    msg_ready_i = 1'b1;
    checkOutput("node_pop");
    node_row_i  = 4'd2;
    node_col_i  = 4'd2;

    // Mixed traffic around the node, including self targets and stalls
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << PW) - 1)),
                    1'($urandom_range(0, 2) != 0));
      checkOutput("mixed");
    end
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("mixed_drain1");
    checkOutput("mixed_drain2");

    // Reset with two messages queued discards them
    applyStimulus(1'b1, 3, 3, 0, 1'b0, 'h00101, 1'b0);
    checkOutput("rstq_a");
    applyStimulus(1'b1, 1, 1, 0, 1'b0, 'h00202, 1'b0);
    checkOutput("rstq_b");
    rst_i = 1'b1;
    applyStimulus(1'b1, 3, 1, 0, 1'b0, 'h00303, 1'b1);
    #1;
    check("rstq.msg_valid", 32'(msg_valid_o), 32'd0);
    check("rstq.msg_data", msg_data_o, 32'd0);
    check("rstq.sent", 32'(sent_count_o), 32'd0);
    check("rstq.drop", 32'(drop_count_o), 32'd0);
    check("rstq.req_ready", 32'(req_ready_o), 32'd1);
    exp_q.delete();
    model_cnt = 0;
    exp_sent  = 16'd0;
    exp_drop  = 16'd0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rstq.held_valid", 32'(msg_valid_o), 32'd0);
    rst_i = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("rstq_after1");
    checkOutput("rstq_after2");

    // Sent counter saturates
    force dut.sent_cnt_q = 16'hFFFE;
    #1;
    release dut.sent_cnt_q;
    exp_sent = 16'hFFFE;
    applyStimulus(1'b1, 1, 3, 0, 1'b0, 'h00001, 1'b1);
    checkOutput("sat_1");
    applyStimulus(1'b1, 3, 0, 1, 1'b0, 'h00002, 1'b1);
    checkOutput("sat_2");
    applyStimulus(1'b1, 2, 0, 2, 1'b1, 'h00003, 1'b1);
    checkOutput("sat_3");
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("sat_drain");
    checkOutput("sat_hold");
    check("sat.final", 32'(sent_count_o), 32'h0000FFFF);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
